// File: rtl/micro_reg_file_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// micro_reg_file_ctrl
//
// Initiator side of the micro register file access interface. Accepts one
// operand-fetch / write-back command per handshake from decode and sequences
// up to two reads (A, then B) and one write (W) onto micro_reg_file. Each
// access is lined up with one EXECUTE1/EXECUTE2 pair of the CPU state. Read
// data is captured into op_a / op_b and completion is flagged with op_valid.
//
// Optional feature macro: MICRO_REG_WB_VERIFY_EN
//   When defined, every write is followed by a read-back of the written
//   register. The read value is compared with the written value and a
//   mismatch sets err. op_a / op_b are left untouched by the read-back.
//
// Ports
//   sys_clk      in   clock, rising edge
//   sys_reset    in   synchronous reset, active low
//   cpu_state    in   CPU state; only EXECUTE1 / EXECUTE2 matter here
//   cmd_valid    in   command offered
//   cmd_ready    out  controller idle and accepting
//   cmd_rd_a/b   in   read enables for operand A / B
//   cmd_wr       in   write-back enable
//   cmd_sel_a/b/d in  register selects for A, B and write-back
//   cmd_wr_data  in   write-back value
//   reg_file_en  out  register file access enable
//   reg_file_rw  out  REG_FILE_READ / REG_FILE_WRITE
//   reg_sel      out  register select
//   reg_wr_data  out  write data (0 during reads)
//   reg_rd_data  in   read data from register file
//   op_a/op_b    out  captured operands
//   op_valid     out  one-cycle completion pulse
//   err          out  sticky sequencing / verify error
// -----------------------------------------------------------------------------
`ifndef DATA_WIDTH
  `define DATA_WIDTH 8
`endif
`ifndef REG_SPEC_WIDTH
  `define REG_SPEC_WIDTH 2
`endif
`ifndef CPU_STATES
  `define CPU_STATES 8
`endif
`ifndef EXECUTE1
  `define EXECUTE1 3
`endif
`ifndef EXECUTE2
  `define EXECUTE2 4
`endif
`ifndef REG_FILE_READ
  `define REG_FILE_READ 1'b1
`endif
`ifndef REG_FILE_WRITE
  `define REG_FILE_WRITE 1'b0
`endif

module micro_reg_file_ctrl #(
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int REG_SPEC_WIDTH = `REG_SPEC_WIDTH
) (
  input  logic                              sys_clk,
  input  logic                              sys_reset,
  input  logic [$clog2(`CPU_STATES)-1:0]    cpu_state,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_rd_a,
  input  logic                              cmd_rd_b,
  input  logic                              cmd_wr,
  input  logic [REG_SPEC_WIDTH-1:0]         cmd_sel_a,
  input  logic [REG_SPEC_WIDTH-1:0]         cmd_sel_b,
  input  logic [REG_SPEC_WIDTH-1:0]         cmd_sel_d,
  input  logic [DATA_WIDTH-1:0]             cmd_wr_data,
  output logic                              reg_file_en,
  output logic                              reg_file_rw,
  output logic [REG_SPEC_WIDTH-1:0]         reg_sel,
  output logic [DATA_WIDTH-1:0]             reg_wr_data,
  input  logic [DATA_WIDTH-1:0]             reg_rd_data,
  output logic [DATA_WIDTH-1:0]             op_a,
  output logic [DATA_WIDTH-1:0]             op_b,
  output logic                              op_valid,
  output logic                              err
);

  localparam int CPU_W = $clog2(`CPU_STATES);
  localparam logic [CPU_W-1:0] EXEC1 = CPU_W'(`EXECUTE1);
  localparam logic [CPU_W-1:0] EXEC2 = CPU_W'(`EXECUTE2);
  localparam logic RW_READ  = `REG_FILE_READ;
  localparam logic RW_WRITE = `REG_FILE_WRITE;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ARM_A = 4'd1;
  localparam logic [3:0] S_E1_A  = 4'd2;
  localparam logic [3:0] S_CAP_A = 4'd3;
  localparam logic [3:0] S_ARM_B = 4'd4;
  localparam logic [3:0] S_E1_B  = 4'd5;
  localparam logic [3:0] S_CAP_B = 4'd6;
  localparam logic [3:0] S_ARM_W = 4'd7;
  localparam logic [3:0] S_E1_W  = 4'd8;
  localparam logic [3:0] S_CAP_W = 4'd9;
`ifdef MICRO_REG_WB_VERIFY_EN
  localparam logic [3:0] S_ARM_V = 4'd10;
  localparam logic [3:0] S_E1_V  = 4'd11;
  localparam logic [3:0] S_CAP_V = 4'd12;
`endif
  localparam logic [3:0] S_DONE  = 4'd13;

  logic [3:0]                state_reg, state_next;
  logic                      cmd_ready_reg;
  logic                      rd_b_reg, wr_reg;
  logic [REG_SPEC_WIDTH-1:0] sel_a_reg, sel_b_reg, sel_d_reg;
  logic [DATA_WIDTH-1:0]     wr_data_reg;
  logic                      en_reg, en_next;
  logic                      rw_reg, rw_next;
  logic [REG_SPEC_WIDTH-1:0] sel_reg, sel_next;
  logic [DATA_WIDTH-1:0]     wd_reg, wd_next;
  logic [DATA_WIDTH-1:0]     op_a_reg, op_b_reg;
  logic                      op_valid_reg;
  logic                      err_reg;
  logic                      accept;
  logic                      in_e1;
  logic [REG_SPEC_WIDTH-1:0] cur_sel_a, cur_sel_b, cur_sel_d;
  logic [DATA_WIDTH-1:0]     cur_wr_data;

  // Next access in the fixed A -> B -> W order; DONE when nothing is left.
  function automatic logic [3:0] next_access(input logic a, input logic b, input logic w);
    if (a)      return S_ARM_A;
    else if (b) return S_ARM_B;
    else if (w) return S_ARM_W;
    else        return S_DONE;
  endfunction

  assign accept = cmd_valid && cmd_ready_reg;

  // On the acceptance edge the latches are not loaded yet, so the first
  // access takes its select/data straight from the command inputs.
  assign cur_sel_a   = (state_reg == S_IDLE) ? cmd_sel_a   : sel_a_reg;
  assign cur_sel_b   = (state_reg == S_IDLE) ? cmd_sel_b   : sel_b_reg;
  assign cur_sel_d   = (state_reg == S_IDLE) ? cmd_sel_d   : sel_d_reg;
  assign cur_wr_data = (state_reg == S_IDLE) ? cmd_wr_data : wr_data_reg;

  always_comb begin
    in_e1 = (state_reg == S_E1_A) || (state_reg == S_E1_B) || (state_reg == S_E1_W);
`ifdef MICRO_REG_WB_VERIFY_EN
    in_e1 = in_e1 || (state_reg == S_E1_V);
`endif
  end

  // Next-state logic. An E1 state not followed by EXECUTE2 falls back to
  // its ARM state and waits for the next EXECUTE1.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = next_access(cmd_rd_a, cmd_rd_b, cmd_wr);
      S_ARM_A: if (cpu_state == EXEC1) state_next = S_E1_A;
      S_E1_A:  state_next = (cpu_state == EXEC2) ? S_CAP_A : S_ARM_A;
      S_CAP_A: state_next = next_access(1'b0, rd_b_reg, wr_reg);
      S_ARM_B: if (cpu_state == EXEC1) state_next = S_E1_B;
      S_E1_B:  state_next = (cpu_state == EXEC2) ? S_CAP_B : S_ARM_B;
      S_CAP_B: state_next = next_access(1'b0, 1'b0, wr_reg);
      S_ARM_W: if (cpu_state == EXEC1) state_next = S_E1_W;
      S_E1_W:  state_next = (cpu_state == EXEC2) ? S_CAP_W : S_ARM_W;
`ifdef MICRO_REG_WB_VERIFY_EN
      S_CAP_W: state_next = S_ARM_V;
      S_ARM_V: if (cpu_state == EXEC1) state_next = S_E1_V;
      S_E1_V:  state_next = (cpu_state == EXEC2) ? S_CAP_V : S_ARM_V;
      S_CAP_V: state_next = S_DONE;
`else
      S_CAP_W: state_next = S_DONE;
`endif
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Bus registers: loaded when entering (or re-entering) an ARM state, held
  // through E1, enable dropped for CAP. Select/rw/data keep their last value
  // outside an access.
  always_comb begin
    en_next  = en_reg;
    rw_next  = rw_reg;
    sel_next = sel_reg;
    wd_next  = wd_reg;
    case (state_next)
      S_ARM_A: begin
        en_next = 1'b1; rw_next = RW_READ;  sel_next = cur_sel_a; wd_next = '0;
      end
      S_ARM_B: begin
        en_next = 1'b1; rw_next = RW_READ;  sel_next = cur_sel_b; wd_next = '0;
      end
      S_ARM_W: begin
        en_next = 1'b1; rw_next = RW_WRITE; sel_next = cur_sel_d; wd_next = cur_wr_data;
      end
`ifdef MICRO_REG_WB_VERIFY_EN
      S_ARM_V: begin
        en_next = 1'b1; rw_next = RW_READ;  sel_next = sel_d_reg; wd_next = '0;
      end
      S_CAP_V: en_next = 1'b0;
`endif
      S_CAP_A, S_CAP_B, S_CAP_W: en_next = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset) begin
      state_reg     <= S_IDLE;
      cmd_ready_reg <= 1'b0;
      rd_b_reg      <= 1'b0;
      wr_reg        <= 1'b0;
      sel_a_reg     <= '0;
      sel_b_reg     <= '0;
      sel_d_reg     <= '0;
      wr_data_reg   <= '0;
      en_reg        <= 1'b0;
      rw_reg        <= RW_READ;
      sel_reg       <= '0;
      wd_reg        <= '0;
      op_a_reg      <= '0;
      op_b_reg      <= '0;
      op_valid_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_ready_reg <= (state_next == S_IDLE);
      op_valid_reg  <= (state_next == S_DONE);
      en_reg        <= en_next;
      rw_reg        <= rw_next;
      sel_reg       <= sel_next;
      wd_reg        <= wd_next;
      if (accept) begin
        rd_b_reg    <= cmd_rd_b;
        wr_reg      <= cmd_wr;
        sel_a_reg   <= cmd_sel_a;
        sel_b_reg   <= cmd_sel_b;
        sel_d_reg   <= cmd_sel_d;
        wr_data_reg <= cmd_wr_data;
      end
      if (state_reg == S_CAP_A) op_a_reg <= reg_rd_data;
      if (state_reg == S_CAP_B) op_b_reg <= reg_rd_data;
      if (in_e1 && (cpu_state != EXEC2)) err_reg <= 1'b1;
`ifdef MICRO_REG_WB_VERIFY_EN
      if ((state_reg == S_CAP_V) && (reg_rd_data != wr_data_reg)) err_reg <= 1'b1;
`endif
    end
  end

  assign cmd_ready   = cmd_ready_reg;
  assign reg_file_en = en_reg;
  assign reg_file_rw = rw_reg;
  assign reg_sel     = sel_reg;
  assign reg_wr_data = wd_reg;
  assign op_a        = op_a_reg;
  assign op_b        = op_b_reg;
  assign op_valid    = op_valid_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_micro_reg_file_ctrl.sv
`timescale 1ns/1ps
`ifndef DATA_WIDTH
  `define DATA_WIDTH 8
`endif
`ifndef REG_SPEC_WIDTH
  `define REG_SPEC_WIDTH 2
`endif
`ifndef CPU_STATES
  `define CPU_STATES 8
`endif
`ifndef EXECUTE1
  `define EXECUTE1 3
`endif
`ifndef EXECUTE2
  `define EXECUTE2 4
`endif
`ifndef REG_FILE_READ
  `define REG_FILE_READ 1'b1
`endif
`ifndef REG_FILE_WRITE
  `define REG_FILE_WRITE 1'b0
`endif

module tb_micro_reg_file_ctrl;
  localparam int DW = 8;
  localparam int RW = 2;
  localparam int CW = $clog2(`CPU_STATES);
  localparam logic [CW-1:0] E1 = CW'(`EXECUTE1);
  localparam logic [CW-1:0] E2 = CW'(`EXECUTE2);
  localparam logic RD_C = `REG_FILE_READ;
  localparam logic WR_C = `REG_FILE_WRITE;
`ifdef MICRO_REG_WB_VERIFY_EN
  localparam int WR_ACC = 2;
`else
  localparam int WR_ACC = 1;
`endif

  logic          sys_clk, sys_reset;
  logic [CW-1:0] cpu_state;
  logic          cmd_valid, cmd_ready, cmd_rd_a, cmd_rd_b, cmd_wr;
  logic [RW-1:0] cmd_sel_a, cmd_sel_b, cmd_sel_d;
  logic [DW-1:0] cmd_wr_data;
  logic          reg_file_en, reg_file_rw;
  logic [RW-1:0] reg_sel;
  logic [DW-1:0] reg_wr_data, reg_rd_data, op_a, op_b;
  logic          op_valid, err;

  micro_reg_file_ctrl #(.DATA_WIDTH(DW), .REG_SPEC_WIDTH(RW)) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .cpu_state(cpu_state),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rd_a(cmd_rd_a), .cmd_rd_b(cmd_rd_b), .cmd_wr(cmd_wr),
    .cmd_sel_a(cmd_sel_a), .cmd_sel_b(cmd_sel_b), .cmd_sel_d(cmd_sel_d),
    .cmd_wr_data(cmd_wr_data),
    .reg_file_en(reg_file_en), .reg_file_rw(reg_file_rw), .reg_sel(reg_sel),
    .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .err(err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Register file stand-in: acts on the EXECUTE2 cycle of an enabled access.
  logic [DW-1:0] rf_mem [4];
  logic [DW-1:0] rf_q;
  logic          corrupt;
  always @(posedge sys_clk) begin
    if (reg_file_en && cpu_state == E2) begin
      if (reg_file_rw == WR_C) rf_mem[reg_sel] <= reg_wr_data;
      else                     rf_q <= rf_mem[reg_sel];
    end
  end
  assign reg_rd_data = corrupt ? '0 : rf_q;

  // Reference model and scoreboard
  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          e;
    int            acc_cyc;
    int            lat;
  } exp_t;
  exp_t          sb[$];
  logic [DW-1:0] m_regs [4];
  logic [DW-1:0] m_a, m_b;
  logic          m_err;
  int            cyc, tests, fails;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: one line per completed command.
  initial begin
    exp_t e;
    cyc = 0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (op_valid === 1'b1) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL spurious_op_valid: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          $display("[TB] done cyc=%0d op_a=%0h op_b=%0h err=%0b", cyc, op_a, op_b, err);
          chk("op_a", 32'(op_a), 32'(e.a));
          chk("op_b", 32'(op_b), 32'(e.b));
          chk("err", 32'(err), 32'(e.e));
          if (e.lat >= 0) chk("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
        end
      end
    end
  end

  // Offer a command, wait for acceptance, push the expected response.
  // Returns at the falling edge of the first cycle after acceptance.
  task automatic send(input logic ra, input logic rb, input logic w,
                      input logic [RW-1:0] sa, input logic [RW-1:0] sbs, input logic [RW-1:0] sd,
                      input logic [DW-1:0] d, input int lat, input bit push);
    exp_t e;
    int n;
    cpu_state = '0;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge sys_clk); n++; end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_rd_a = ra; cmd_rd_b = rb; cmd_wr = w;
    cmd_sel_a = sa; cmd_sel_b = sbs; cmd_sel_d = sd; cmd_wr_data = d;
    @(posedge sys_clk);
    e.acc_cyc = cyc;
    if (ra) m_a = m_regs[sa];
    if (rb) m_b = m_regs[sbs];
    if (w)  m_regs[sd] = d;
    e.a = m_a; e.b = m_b; e.e = m_err; e.lat = lat;
    if (push) sb.push_back(e);
    $display("[TB] cmd cyc=%0d rd_a=%0b rd_b=%0b wr=%0b sa=%0d sb=%0d sd=%0d d=%0h",
             cyc, ra, rb, w, sa, sbs, sd, d);
    @(negedge sys_clk);
    cmd_valid = 1'b0;
  endtask

  task automatic step(input logic [CW-1:0] s);
    cpu_state = s;
    @(negedge sys_clk);
  endtask

  task automatic triples(input int n);
    repeat (n) begin step(E1); step(E2); step('0); end
  endtask

  task automatic wait_idle();
    int n = 0;
    cpu_state = '0;
    while (cmd_ready !== 1'b1 && n < 300) begin @(negedge sys_clk); n++; end
    chk("idle_wait", 32'(cmd_ready), 32'd1);
  endtask

  // Random CPU state stream in which every EXECUTE1 is followed by EXECUTE2.
  task automatic rand_run();
    bit prev_e1 = 1'b0;
    int n = 0;
    logic [CW-1:0] s;
    while (cmd_ready !== 1'b1 && n < 400) begin
      if (prev_e1) begin s = E2; prev_e1 = 1'b0; end
      else if ($urandom_range(0, 2) == 0) begin s = E1; prev_e1 = 1'b1; end
      else s = CW'($urandom_range(0, 2));
      step(s);
      n++;
    end
    chk("idle_wait_rand", 32'(cmd_ready), 32'd1);
  endtask

  task automatic chk_bus(input string nm, input logic en, input logic rw,
                         input logic [RW-1:0] sel, input logic [DW-1:0] wd);
    chk({nm, "_en"},  32'(reg_file_en), 32'(en));
    chk({nm, "_rw"},  32'(reg_file_rw), 32'(rw));
    chk({nm, "_sel"}, 32'(reg_sel),     32'(sel));
    chk({nm, "_wd"},  32'(reg_wr_data), 32'(wd));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ra, rb, w;
    tests = 0; fails = 0;
    m_a = '0; m_b = '0; m_err = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    corrupt = 1'b0;
    sys_reset = 1'b0; cpu_state = '0; cmd_valid = 1'b0;
    cmd_rd_a = 1'b0; cmd_rd_b = 1'b0; cmd_wr = 1'b0;
    cmd_sel_a = '0; cmd_sel_b = '0; cmd_sel_d = '0; cmd_wr_data = '0;

    // Reset held for two cycles
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk_bus("rst_bus", 1'b0, RD_C, '0, '0);
    chk("rst_op_a", 32'(op_a), 32'd0);
    chk("rst_op_b", 32'(op_b), 32'd0);
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    sys_reset = 1'b1;
    @(negedge sys_clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Write A4 to reg0 with bus checks
    send(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 8'hA4, 3 * WR_ACC + 1, 1'b1);
    chk_bus("wr_arm", 1'b1, WR_C, 2'd0, 8'hA4);
    step(E1);
    chk_bus("wr_e1", 1'b1, WR_C, 2'd0, 8'hA4);
    step(E2);
    chk("wr_cap_en", 32'(reg_file_en), 32'd0);
    step('0);
    triples(WR_ACC - 1);
    wait_idle();

    // Read A of reg0
    send(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 4, 1'b1);
    triples(1); wait_idle();

    // Preload reg1..reg3
    send(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 8'h11, 3 * WR_ACC + 1, 1'b1);
    triples(WR_ACC); wait_idle();
    send(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd2, 8'h22, 3 * WR_ACC + 1, 1'b1);
    triples(WR_ACC); wait_idle();
    send(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd3, 8'h3C, 3 * WR_ACC + 1, 1'b1);
    triples(WR_ACC); wait_idle();

    // Two-operand read: latency 7
    send(1'b1, 1'b1, 1'b0, 2'd1, 2'd2, 2'd0, 8'h00, 7, 1'b1);
    triples(2); wait_idle();

    // All three accesses; reads see values before the write
    send(1'b1, 1'b1, 1'b1, 2'd3, 2'd1, 2'd3, 8'h77, 3 * (2 + WR_ACC) + 1, 1'b1);
    triples(2 + WR_ACC); wait_idle();

    // No-op command completes in the cycle after acceptance
    send(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 8'h00, 1, 1'b1);
    wait_idle();

    // Stall: five non-EXECUTE cycles in ARM_B
    send(1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 2'd0, 8'h00, 9, 1'b1);
    chk_bus("stall_c1", 1'b1, RD_C, 2'd3, 8'h00);
    repeat (5) step(CW'(1));
    chk_bus("stall_c6", 1'b1, RD_C, 2'd3, 8'h00);
    triples(1); wait_idle();
    chk("stall_err", 32'(err), 32'd0);

    // Sequencing violation: EXECUTE1 followed by EXECUTE1, then retry
    m_err = 1'b1;
    send(1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 8'h00, 7, 1'b1);
    step(E1); step(E1); step('0);
    triples(1); wait_idle();
    // err stays set on later commands
    send(1'b0, 1'b1, 1'b0, 2'd0, 2'd2, 2'd0, 8'h00, 4, 1'b1);
    triples(1); wait_idle();

    // Reset during E1_B: bus idles, no completion pulse
    send(1'b1, 1'b1, 1'b0, 2'd1, 2'd2, 2'd0, 8'h00, -1, 1'b0);
    step(E1); step(E2); step('0); step(E1);
    sys_reset = 1'b0; cpu_state = E2;
    @(negedge sys_clk);
    chk("midrst_en", 32'(reg_file_en), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_op_a", 32'(op_a), 32'd0);
    m_a = '0; m_b = '0; m_err = 1'b0;
    sys_reset = 1'b1; cpu_state = '0;
    @(negedge sys_clk);
    chk("midrst_idle", 32'(cmd_ready), 32'd1);
    repeat (3) step(E1);

    // Randomized commands against the model
    for (int i = 0; i < 40; i++) begin
      ra = 1'($urandom); rb = 1'($urandom); w = 1'($urandom);
      send(ra, rb, w, RW'($urandom), RW'($urandom), RW'($urandom), DW'($urandom),
           (!ra && !rb && !w) ? 1 : -1, 1'b1);
      rand_run();
    end

`ifdef MICRO_REG_WB_VERIFY_EN
    // Read-back returns 00 for a write of 5A
    m_err = 1'b1;
    corrupt = 1'b1;
    send(1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 8'h5A, 7, 1'b1);
    triples(2); wait_idle();
    corrupt = 1'b0;
`endif

    repeat (5) @(negedge sys_clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/micro_reg_file_ctrl.md
# micro_reg_file_ctrl

Initiator side of the micro register file access interface. It accepts one operand-fetch/write-back command per handshake from the decode stage and sequences up to two reads and one write onto `micro_reg_file`. Each access is aligned to one EXECUTE1/EXECUTE2 pair of the CPU state. It captures read data into operand latches for the ALU and signals completion.

## Interface
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (8): register data width.
- `REG_SPEC_WIDTH`, default `` `REG_SPEC_WIDTH `` (2): register select width.
- `sys_clk`  in  1  clock; all state updates on the rising edge.
- `sys_reset`  in  1  reset, synchronous, active-low.
- `cpu_state`  in  `$clog2(`CPU_STATES)`  current CPU state; only `` `EXECUTE1 `` and `` `EXECUTE2 `` are significant here.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  controller idle and accepting.
- `cmd_rd_a`, `cmd_rd_b`, `cmd_wr`  in  1 each  access enables.
- `cmd_sel_a`, `cmd_sel_b`, `cmd_sel_d`  in  `REG_SPEC_WIDTH` each  register selects.
- `cmd_wr_data`  in  `DATA_WIDTH`  write-back value.
- `reg_file_en`, `reg_file_rw`  out  1 each  to register file.
- `reg_sel`  out  `REG_SPEC_WIDTH`  to register file.
- `reg_wr_data`  out  `DATA_WIDTH`  to register file.
- `reg_rd_data`  in  `DATA_WIDTH`  from register file.
- `op_a`, `op_b`  out  `DATA_WIDTH` each  captured operands.
- `op_valid`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky sequencing/verify error; cleared only by reset.

## Operation
- Handshake: a command is accepted on a rising edge with `cmd_valid && cmd_ready`. All `cmd_*` fields are latched at acceptance. `cmd_ready` is high only in IDLE.
- Access order is fixed: RD_A (if `cmd_rd_a`), then RD_B (if `cmd_rd_b`), then WR (if `cmd_wr`). Disabled accesses are skipped.
- A command with all three enables low completes with `op_valid` in the cycle after acceptance. Operands are unchanged.
- Each access runs three phases:
  - **ARM**: `reg_file_en`, `reg_file_rw`, `reg_sel`, and `reg_wr_data` are driven from registers. They hold constant until the access ends. The controller waits here for `cpu_state == EXECUTE1`.
  - **E1**: entered after the EXECUTE1 cycle. The next cycle must be `EXECUTE2`.
  - **CAP**: for reads, `reg_rd_data` is sampled at the end of this cycle into `op_a` or `op_b`. `reg_file_en` drops to 0 during CAP.
- FSM states: IDLE, ARM_A, E1_A, CAP_A, ARM_B, E1_B, CAP_B, ARM_W, E1_W, CAP_W, (VERIFY group, see Configuration), DONE.
- DONE lasts one cycle and asserts `op_valid`, then returns to IDLE.
- Sequencing violation: if the cycle after EXECUTE1 is not EXECUTE2:
  - set `err`;
  - return to the same ARM state and retry at the next EXECUTE1;
  - outputs stay driven.
- `reg_file_rw` uses `` `REG_FILE_READ `` / `` `REG_FILE_WRITE ``. `reg_wr_data` is 0 during reads.
- Reset has priority over everything, including mid-access. The reset-value bullet lists every output's value; FSM returns to IDLE.
- Reset values:
  - `reg_file_en` 0, `reg_file_rw` READ, `reg_sel` 0, `reg_wr_data` 0;
  - `op_a`/`op_b` 0, `op_valid` 0, `err` 0;
  - `cmd_ready` 0 while reset is asserted, 1 from the first cycle after release.

## Timing
- Per access: cycles spent in ARM before EXECUTE1 arrives, plus EXECUTE1 cycle, EXECUTE2 cycle, and 1 CAP cycle. With EXECUTE1 present immediately, this is 3 cycles.
- Command latency with back-to-back EXECUTE1/EXECUTE2 availability is 3 × (number of accesses) + 1 cycles to `op_valid`, measured from acceptance (DONE included).
- `op_a` and `op_b` are stable from `op_valid` until the next capture of the same operand.
- No new command is accepted before the cycle after DONE.

## Configuration
- `MICRO_REG_WB_VERIFY_EN` defined:
  - after WR completes, a read of `cmd_sel_d` runs with the same ARM/E1/CAP timing;
  - the read value is compared to `cmd_wr_data`;
  - a mismatch sets `err`;
  - `op_a`/`op_b` are not modified;
  - this adds 3 cycles to write commands.
- Undefined: no verify states; WR is followed directly by DONE.

## Test plan
- Reset: hold `sys_reset` = 0 for 2 cycles -> all outputs at reset values; `cmd_ready` = 1 in the cycle after release.
- Write then read:
  - write-only command `sel_d`=0, data 8'hA4, EXECUTE1/EXECUTE2 supplied -> `reg_file_en`=1, rw=WRITE, `reg_sel`=0, `reg_wr_data`=A4 held 2 cycles; `op_valid` 4 cycles after acceptance;
  - then read-A of reg 0 -> `op_a`=8'hA4.
- Two-operand read: reg1=8'h11, reg2=8'h22, `rd_a`=1 `rd_b`=1 -> `op_a`=11, `op_b`=22; `op_valid` exactly 7 cycles after acceptance.
- Stall: hold `cpu_state` in a non-EXECUTE state for 5 cycles after acceptance -> bus held constant in ARM; latency grows by 5; `err`=0.
- Sequencing violation: EXECUTE1 followed by EXECUTE1 -> `err`=1; access retried; `op_a` still correct; `err` stays 1 until reset.
- Reset mid-access: assert reset during E1_B -> next cycle `reg_file_en`=0, FSM IDLE, `op_valid` never pulses.
- With `MICRO_REG_WB_VERIFY_EN`: force `reg_rd_data` = 8'h00 during verify of a write of 8'h5A -> `err`=1; `op_valid` at 7 cycles after acceptance.
